// File: rtl/data_mem_pipe.sv
// Byte-addressed single-port data RAM with pipelined read latency,
// sub-word access, fault checking and a post-reset preload sequencer.
module data_mem_pipe #(
  parameter int DEPTH     = 64,
  parameter int READ_LAT  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdata,
  output logic        init_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        we;
    logic        sext;
    logic [1:0]  size;
    logic [1:0]  lane;
    logic [31:0] word;
  } stg_t;

  state_e      state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic [31:0] mem_q [DEPTH];
  stg_t        pipe_q [READ_LAT];
  stg_t        stg_d;
  stg_t        last;

  logic          accept;
  logic          fault;
  logic          init_we;
  logic [31:0]   init_word;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld;

  assign ready     = (state_q == RUN);
  assign init_busy = (state_q == INIT);
  assign accept    = req & ready;
  assign widx      = addr[AW+1:2];
  assign init_word = (INIT_MODE != 0) ? 32'(idx_q) : '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    init_we = 1'b0;
    if (state_q == INIT) begin
      init_we = 1'b1;
      idx_d   = idx_q + 1'b1;
      if (idx_q == LAST) state_d = RUN;
    end
  end

  always_comb begin
    fault = |addr[31:AW+2];
    be    = 4'b0000;
    wlane = wdata;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        fault = fault | addr[0];
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
      end
      2'b10: begin
        fault = fault | (|addr[1:0]);
        be    = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    stg_d.valid = accept;
    stg_d.err   = fault;
    stg_d.we    = we;
    stg_d.sext  = sign_ext;
    stg_d.size  = size;
    stg_d.lane  = addr[1:0];
    stg_d.word  = mem_q[widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pipe_q[0] <= stg_d;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Init and store never overlap: stores need ready, which is RUN only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        mem_q[idx_q[AW-1:0]] <= init_word;
      end else if (accept && we && !fault) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mem_q[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign last = pipe_q[READ_LAT-1];
  assign ld_b = last.word[8*last.lane +: 8];
  assign ld_h = last.word[16*last.lane[1] +: 16];

  always_comb begin
    ld = '0;
    unique case (last.size)
      2'b00:   ld = {{24{last.sext & ld_b[7]}}, ld_b};
      2'b01:   ld = {{16{last.sext & ld_h[15]}}, ld_h};
      2'b10:   ld = last.word;
      default: ld = '0;
    endcase
  end

  assign resp_valid = last.valid;
  assign resp_err   = last.valid & last.err;
  assign rdata      = (last.valid & ~last.err & ~last.we) ? ld : '0;

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
Parametrised successor to the processor's data memory. Single-port, byte-addressed RAM with byte, half and word access, sign/zero extension, and alignment/range checking. It has a configurable pipelined read latency and a valid/ready request interface. After reset, a sequential init FSM preloads contents; the core's MEM stage stalls on ready.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 4..1024
READ_LAT, 1, cycles from request acceptance to response; 1..4
INIT_MODE, 1, 0 = all words zero; 1 = mem[i] = i (word index, zero-extended)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
req  in  1  request valid
we  in  1  1 = store, 0 = load
addr  in  32  byte address
size  in  2  00 byte, 01 half, 10 word, 11 illegal
sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
ready  out  1  block accepts a request this cycle
resp_valid  out  1  one-cycle response pulse, one per accepted request
resp_err  out  1  qualifies resp_valid: request was faulted
rdata  out  32  load result; 0 for stores and faulted requests
init_busy  out  1  init FSM active

Behaviour:
- Reset value of every output is 0, except init_busy = 1. Any edge with rst = 1 forces state INIT with index = 0 and flushes the response pipeline. In-flight responses are dropped, never delivered.
- FSM has two states, INIT and RUN.
  - INIT: writes the INIT_MODE pattern to mem[index] on each rst = 0 edge, then increments index. After writing mem[DEPTH-1], moves to RUN.
  - INIT timing: ready = 1 and init_busy = 0 exactly after DEPTH rising edges with rst = 0.
  - In INIT, ready = 0 and req is ignored (no response is generated).
- RUN: ready = 1 every cycle, so the block is fully pipelined at one request per cycle. A request is accepted on an edge where req & ready.
- Address decode: word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0]; little-endian.
- Fault conditions (checked at acceptance):
  - size = 11
  - half access with addr[0] = 1
  - word access with addr[1:0] != 0
  - addr >= 4*DEPTH
- A faulted request does not modify memory and returns resp_err = 1, rdata = 0.
- Store: committed on the accepting edge, touching only the addressed lanes. Byte writes lane addr[1:0] with wdata[7:0]. Half writes lanes addr[1]*2+{0,1} with wdata[15:0]. Other lanes are preserved.
- Load: the word is read on the accepting edge; lane extraction and extension happen in the pipeline. Byte/half results are extended from bit 7/15 per sign_ext; word ignores sign_ext.
- Response timing: resp_valid for a request accepted at edge N is high in the cycle after edge N+READ_LAT-1. READ_LAT = 1 means visible the cycle immediately after acceptance.
  - Responses return in order, one per accepted request, including stores (resp_err = 0, rdata = 0).
  - When resp_valid = 0, rdata = 0 and resp_err = 0.
- Read-after-write: a load accepted on the edge after a store to the same word returns the updated data. Same-edge load and store cannot occur (single port).
- Arithmetic: index counter is log2(DEPTH)+1 bits wide and does not wrap. Address bits above the range check are not aliased.

Test Plan:
- Init, DEPTH = 64, INIT_MODE = 1: deassert rst -> ready rises after exactly 64 edges, init_busy falls on the same cycle. Load word @0x14 -> rdata 0x00000005, resp_err 0. req held high during INIT -> no resp_valid.
- Sub-word store/load: byte store 0x80 @0x09, then loads -> lb @0x09 = 0xFFFFFF80, lbu @0x09 = 0x00000080, lw @0x08 = 0x00008002. Half store 0xBEEF @0x0E -> lw @0x0C = 0xBEEF0003.
- Faults: lw @0x02, lh @0x05, size = 11 @0x00, and sw @0x100 (DEPTH = 64) -> each gives resp_valid with resp_err = 1, rdata = 0. Subsequent lw @0x00 returns 0x00000000, confirming memory is unchanged.
- Pipelining, READ_LAT = 3: back-to-back sw 0xDEADBEEF @0x10, lw @0x10, lw @0x14 on consecutive edges -> three consecutive resp_valid pulses starting 3 cycles after the first acceptance, rdata = 0, 0xDEADBEEF, 0x00000005.
- Reset mid-operation: with two loads in flight at READ_LAT = 4, assert rst for one edge -> no resp_valid for them, ready = 0, and INIT restarts. After 64 edges, earlier stores are overwritten: lw @0x10 = 0x00000004.
- Parameter sweep: DEPTH = 4, READ_LAT = 1, INIT_MODE = 0 -> ready after 4 edges, lw @0x0C = 0, lw @0x10 faults. Response appears the cycle immediately after acceptance.
